// File: rtl/apb_regfile_slave.sv
// rtl/apb_regfile_slave.sv - parametrised APB register-file slave with wait states and error counting
// Optional byte-strobe writes are enabled with `define APB_REGFILE_PSTRB_EN.
module apb_regfile_slave #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 32,
  parameter int WAIT_CYCLES = 2,
  parameter int SECURE_ONLY = 1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                psel,
  input  logic                penable,
  input  logic                pwrite,
  input  logic [ADDR_W-1:0]   paddr,
  input  logic [DATA_W-1:0]   pwdata,
  input  logic [DATA_W/8-1:0] pstrb,
  input  logic [2:0]          pprot,
  output logic                pready,
  output logic [DATA_W-1:0]   prdata,
  output logic                pslverr,
  output logic [7:0]          err_cnt
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = 4;
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFF_W) - 1);
  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wr_q, wr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                nsec_q, nsec_d;
  logic                pready_q, pready_d;
  logic                pslverr_q, pslverr_d;
  logic [DATA_W-1:0]   prdata_q, prdata_d;
  logic [7:0]          err_cnt_q, err_cnt_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_d [DEPTH];

  logic                setup;
  logic                capture;
  logic                enter_resp;
  logic [ADDR_W-1:0]   cur_addr;
  logic                cur_wr;
  logic [DATA_W-1:0]   cur_wdata;
  logic                cur_nsec;
  logic [STRB_W-1:0]   lane_en;
  logic [ADDR_W-1:0]   cur_idx;
  logic [IDX_W-1:0]    widx;
  logic                xfer_err;
  logic                unused_prot;

  assign setup   = psel & ~penable;
  // A setup seen in IDLE or in the response cycle starts a new transfer.
  assign capture = (state_q != ACCESS) & setup;

  // With zero wait states the commit edge is also the capture edge, so use live inputs.
  assign cur_addr  = capture ? paddr  : addr_q;
  assign cur_wr    = capture ? pwrite : wr_q;
  assign cur_wdata = capture ? pwdata : wdata_q;
  assign cur_nsec  = capture ? pprot[1] : nsec_q;

`ifdef APB_REGFILE_PSTRB_EN
  logic [STRB_W-1:0] strb_q, strb_d;
  logic [STRB_W-1:0] cur_strb;
  assign cur_strb = capture ? pstrb : strb_q;
  assign lane_en  = cur_strb;
  always_comb begin
    strb_d = strb_q;
    if (capture) strb_d = pstrb;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) strb_q <= '0;
    else         strb_q <= strb_d;
  end
`else
  logic unused_pstrb;
  assign unused_pstrb = ^pstrb;
  assign lane_en      = '1;
`endif

  assign unused_prot = pprot[0] ^ pprot[2];

  assign cur_idx  = cur_addr >> OFF_W;
  assign widx     = cur_idx[IDX_W-1:0];
  assign xfer_err = ({1'b0, cur_idx} >= DEPTH_X)
                  | (|(cur_addr & OFF_MASK))
                  | ((SECURE_ONLY != 0) & cur_nsec);

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      nsec_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      nsec_q  <= nsec_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    nsec_d  = nsec_q;
    case (state_q)
      IDLE, RESP: begin
        if (setup) begin
          addr_d  = paddr;
          wr_d    = pwrite;
          wdata_d = pwdata;
          nsec_d  = pprot[1];
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
            cnt_d   = '0;
          end else begin
            state_d = ACCESS;
            cnt_d   = CNT_W'(WAIT_CYCLES);
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (!psel) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (penable) begin
          if (cnt_q <= CNT_W'(1)) begin
            state_d = RESP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign enter_resp = (state_d == RESP);

  // Output and storage logic, all registered on the edge that enters RESP
  always_comb begin
    pready_d  = enter_resp;
    pslverr_d = enter_resp & xfer_err;
    prdata_d  = '0;
    err_cnt_d = err_cnt_q;
    for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
    if (enter_resp) begin
      if (xfer_err) begin
        if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
      end else if (cur_wr) begin
        for (int b = 0; b < STRB_W; b++) begin
          if (lane_en[b]) mem_d[widx][b*8 +: 8] = cur_wdata[b*8 +: 8];
        end
      end else begin
        prdata_d = mem_q[widx];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      err_cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
      err_cnt_q <= err_cnt_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign pready  = pready_q;
  assign pslverr = pslverr_q;
  assign prdata  = prdata_q;
  assign err_cnt = err_cnt_q;

endmodule
